sample_io_bridge: RTL and testbench
===================================

SAMPLE_IO_BRIDGE -- requirements
Module: sample_io_bridge

Interface
REQ-001 The block SHALL have these parameters (name, default, meaning):
- RST_CYCLES, 4, cycles core_rst is held high after a sample is accepted (legal range 1..255).
- COMPUTE_CYCLES, 2000, cycles the core runs before its result is captured (legal range 1..65535).

REQ-002 The block SHALL have these ports (name  direction  width  meaning):
- clk  in  1  single system clock; all state changes on its rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  upstream sample valid.
- in_ready  out  1  bridge can accept a sample.
- in_data  in  31  sample; [30] integer bit, [29:0] fraction.
- core_rst  out  1  reset to the downstream CPU subsystem.
- core_x1  out  1  integer bit of the held sample, to the core.
- core_x2  out  30  fraction of the held sample, to the core.
- core_y1  in  1  core result integer bit.
- core_y2  in  30  core result fraction.
- out_valid  out  1  result valid.
- out_ready  in  1  downstream accepts the result.
- out_data  out  31  captured result {core_y1, core_y2}.
- busy  out  1  high whenever state is not IDLE.
- sample_cnt  out  16  count of completed result handshakes.

Function
REQ-003 The block SHALL implement the four-state FSM IDLE, LOAD, RUN, OUT.
REQ-004 In IDLE, in_ready SHALL be 1; when in_valid and in_ready are both 1 on a rising edge, in_data SHALL be latched into the sample register, the cycle counter cleared, and the state set to LOAD.
REQ-005 In every state other than IDLE, in_ready SHALL be 0 and in_valid SHALL be ignored.
REQ-006 core_rst SHALL be 1 in IDLE, LOAD and OUT, 0 only in RUN, and SHALL be 1 combinationally while rst is high.
REQ-007 LOAD SHALL last exactly RST_CYCLES cycles, then the state SHALL become RUN with the counter cleared.
REQ-008 RUN SHALL last exactly COMPUTE_CYCLES cycles; on its final cycle {core_y1, core_y2} SHALL be registered into out_data and the state SHALL become OUT.
REQ-009 Latency: if a sample is accepted at edge T, out_valid SHALL first be 1 after edge T+RST_CYCLES+COMPUTE_CYCLES+1.
REQ-010 In OUT, out_valid SHALL be 1, and out_data SHALL remain stable regardless of core_y1 or core_y2 until the handshake completes.
REQ-011 On the edge where out_valid and out_ready are both 1, sample_cnt SHALL increment by 1 and the state SHALL become IDLE; a new sample can be accepted no earlier than the following edge.
REQ-012 sample_cnt SHALL wrap from 0xFFFF to 0x0000.
REQ-013 core_x1 and core_x2 SHALL always equal the sample register, which SHALL change only on an accept edge.
REQ-014 The cycle counter SHALL be 16 bits wide and SHALL never exceed max(RST_CYCLES, COMPUTE_CYCLES)-1.
REQ-015 out_ready asserted outside OUT SHALL have no effect.

Reset
REQ-016 When rst is asserted in any state, including mid-LOAD, mid-RUN or mid-OUT, the block SHALL enter IDLE asynchronously with the following values, and any in-flight sample SHALL be discarded with no handshake counted:
- sample register, out_data, counter and sample_cnt = 0
- out_valid = 0, busy = 0, in_ready = 0
- core_rst = 1
REQ-017 in_ready SHALL be 1 from the first rising clk edge after rst deasserts.

Verification (bench settings: RST_CYCLES=4, COMPUTE_CYCLES=10)
REQ-018 Basic: in_data=0x40000000 (1.0) accepted at T, core model drives y=0x20000000 from T+6 -> core_rst high T+1..T+4 and low T+5..T+14; out_valid=1 at T+15 with out_data=0x20000000; sample_cnt=1 after out_ready.
REQ-019 Backpressure: hold out_ready=0 for 20 cycles while the core model toggles y every cycle -> out_valid stays 1, out_data is unchanged, in_ready=0 throughout.
REQ-020 Ignored input: pulse in_valid with 0x7FFFFFFF during RUN -> core_x1/core_x2 unchanged, result corresponds to the first sample.
REQ-021 Mid-run reset: assert rst at T+8 -> core_rst=1, out_valid=0, busy=0 immediately; sample_cnt=0; in_ready=1 on the first edge after release.
REQ-022 Back-to-back with wrap: preload sample_cnt to 0xFFFF via 65535 transactions (or force), complete one more -> sample_cnt=0x0000; with in_valid held high and out_ready=1, consecutive accepts are 16 cycles apart.

Source files
------------

// File: rtl/sample_io_bridge.sv
// sample_io_bridge
// ----------------
// Hands one fixed-point sample at a time to a downstream CPU core. The core is
// held in reset while the sample is loaded, released for a fixed compute
// window, and its result is then captured and presented on a valid/ready
// output port.
//
// Flow: IDLE -> LOAD (RST_CYCLES) -> RUN (COMPUTE_CYCLES) -> OUT -> IDLE
//
// Parameters
//   RST_CYCLES      cycles core_rst stays high after a sample is accepted (1..255)
//   COMPUTE_CYCLES  cycles the core runs before its result is captured (1..65535)
//
// Ports
//   clk, rst             clock; asynchronous active-high reset
//   in_valid/in_ready    upstream handshake; in_data = {int bit, 30-bit fraction}
//   core_rst             reset to the core (low only while the core computes)
//   core_x1/core_x2      held sample (integer bit / fraction) driven to the core
//   core_y1/core_y2      core result (integer bit / fraction)
//   out_valid/out_ready  downstream handshake; out_data = captured {core_y1, core_y2}
//   busy                 high whenever the bridge is not idle
//   sample_cnt           number of completed result handshakes (wraps at 16 bits)
module sample_io_bridge #(
  parameter int RST_CYCLES     = 4,
  parameter int COMPUTE_CYCLES = 2000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [30:0] in_data,
  output logic        core_rst,
  output logic        core_x1,
  output logic [29:0] core_x2,
  input  logic        core_y1,
  input  logic [29:0] core_y2,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [30:0] out_data,
  output logic        busy,
  output logic [15:0] sample_cnt
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2,
    OUT  = 2'd3
  } state_t;

  // Terminal counter values for the two timed phases.
  localparam logic [15:0] LOAD_LAST = 16'(RST_CYCLES - 1);
  localparam logic [15:0] RUN_LAST  = 16'(COMPUTE_CYCLES - 1);

  state_t      state_reg, state_next;
  logic [15:0] cnt_reg, cnt_next;
  logic [30:0] sample_reg;
  logic [30:0] result_reg;
  logic [15:0] sample_cnt_reg;
  // Cleared by reset and set on the first clock edge afterwards, so in_ready
  // stays low while rst is high and rises only once the clock has run.
  logic        armed_reg;

  logic        accept;
  logic        capture;
  logic        handshake;

  // Next-state and phase-timing logic.
  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    accept     = 1'b0;
    capture    = 1'b0;
    handshake  = 1'b0;
    case (state_reg)
      IDLE: begin
        if (in_valid && armed_reg) begin
          accept     = 1'b1;
          cnt_next   = 16'd0;
          state_next = LOAD;
        end
      end
      LOAD: begin
        if (cnt_reg == LOAD_LAST) begin
          cnt_next   = 16'd0;
          state_next = RUN;
        end else begin
          cnt_next = cnt_reg + 16'd1;
        end
      end
      RUN: begin
        if (cnt_reg == RUN_LAST) begin
          // Final compute cycle: the core output is sampled on this edge.
          capture    = 1'b1;
          cnt_next   = 16'd0;
          state_next = OUT;
        end else begin
          cnt_next = cnt_reg + 16'd1;
        end
      end
      OUT: begin
        if (out_ready) begin
          handshake  = 1'b1;
          state_next = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
        cnt_next   = 16'd0;
      end
    endcase
  end

  // State, counter and datapath registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg      <= IDLE;
      cnt_reg        <= 16'd0;
      sample_reg     <= 31'd0;
      result_reg     <= 31'd0;
      sample_cnt_reg <= 16'd0;
      armed_reg      <= 1'b0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      armed_reg <= 1'b1;
      if (accept) begin
        sample_reg <= in_data;
      end
      if (capture) begin
        result_reg <= {core_y1, core_y2};
      end
      if (handshake) begin
        sample_cnt_reg <= sample_cnt_reg + 16'd1;
      end
    end
  end

  assign in_ready   = (state_reg == IDLE) && armed_reg;
  // rst is ORed in so the core is held in reset even before the state
  // register has been cleared.
  assign core_rst   = rst || (state_reg != RUN);
  assign busy       = (state_reg != IDLE);
  assign out_valid  = (state_reg == OUT);
  assign out_data   = result_reg;
  assign core_x1    = sample_reg[30];
  assign core_x2    = sample_reg[29:0];
  assign sample_cnt = sample_cnt_reg;

endmodule

// File: tb/tb_sample_io_bridge.sv
// Testbench for sample_io_bridge (RST_CYCLES=4, COMPUTE_CYCLES=10).
// Expected results are pushed into a queue when a sample is issued; a monitor
// pops and compares on every output handshake.
module tb_sample_io_bridge;

  localparam int RC = 4;
  localparam int CC = 10;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [30:0] in_data = '0;
  logic        core_rst;
  logic        core_x1;
  logic [29:0] core_x2;
  logic        core_y1;
  logic [29:0] core_y2;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [30:0] out_data;
  logic        busy;
  logic [15:0] sample_cnt;

  logic [30:0] y_val = '0;
  logic        core_toggle = 1'b0;
  int          run_len = 0;

  int n_checks = 0;
  int n_fail = 0;
  int cyc = 0;

  typedef struct packed {
    logic [30:0] data;
    logic [15:0] cnt;
  } exp_t;

  exp_t exp_q[$];

  assign core_y1 = y_val[30];
  assign core_y2 = y_val[29:0];

  sample_io_bridge #(
    .RST_CYCLES    (RC),
    .COMPUTE_CYCLES(CC)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .core_rst  (core_rst),
    .core_x1   (core_x1),
    .core_x2   (core_x2),
    .core_y1   (core_y1),
    .core_y2   (core_y2),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .busy      (busy),
    .sample_cnt(sample_cnt)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h required 0x%08h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Core model: output is the held sample shifted right by one, valid from the
  // second compute cycle; zero otherwise. In toggle mode it inverts every cycle.
  initial begin
    forever begin
      @(negedge clk);
      if (core_rst) run_len = 0;
      else run_len++;
      if (core_toggle) y_val = ~y_val;
      else if (run_len >= 2) y_val = {core_x1, core_x2} >> 1;
      else y_val = '0;
    end
  end

  // Scoreboard monitor.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (out_valid && out_ready && !rst) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_result: got 0x%08h required no result", out_data);
        end else begin
          e = exp_q.pop_front();
          check("out_data", 32'(out_data), 32'(e.data));
          @(negedge clk);
          check("sample_cnt", 32'(sample_cnt), 32'(e.cnt));
          $display("txn: out_data=0x%08h sample_cnt=0x%04h (expected 0x%08h / 0x%04h)",
                   out_data, sample_cnt, e.data, e.cnt);
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic send(input logic [30:0] d);
    int k;
    @(posedge clk); #1;
    in_valid = 1'b1;
    in_data  = d;
    k = 0;
    @(negedge clk);
    while (!in_ready && k < 40) begin
      @(negedge clk);
      k++;
    end
    check("send_in_ready", 32'(in_ready), 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_data  = '0;
  endtask

  task automatic wait_out_valid(input int budget);
    int k;
    k = 0;
    @(negedge clk);
    while (!out_valid && k < budget) begin
      @(negedge clk);
      k++;
    end
    check("out_valid_wait", 32'(out_valid), 32'd1);
  endtask

  task automatic handshake_once();
    @(posedge clk); #1;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    @(negedge clk);
    @(negedge clk);
  endtask

  initial begin
    int acc[2];
    int n_acc;
    int guard;

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_in_ready",   32'(in_ready),   32'd0);
    check("rst_core_rst",   32'(core_rst),   32'd1);
    check("rst_busy",       32'(busy),       32'd0);
    check("rst_out_valid",  32'(out_valid),  32'd0);
    check("rst_sample_cnt", 32'(sample_cnt), 32'd0);
    check("rst_out_data",   32'(out_data),   32'd0);
    check("rst_core_x",     32'({core_x1, core_x2}), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("in_ready_after_release", 32'(in_ready), 32'd1);

    // Basic transaction with phase timing
    @(posedge clk); #1;
    in_valid = 1'b1;
    in_data  = 31'h4000_0000;
    exp_q.push_back({31'h2000_0000, 16'd1});
    @(negedge clk);
    check("basic_accept_ready", 32'(in_ready), 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_data  = '0;
    for (int k = 1; k <= 15; k++) begin
      @(negedge clk);
      check($sformatf("basic_core_rst_%0d", k), 32'(core_rst), 32'((k <= RC) || (k == 15)));
      check($sformatf("basic_out_valid_%0d", k), 32'(out_valid), 32'(k == 15));
    end
    check("basic_core_x", 32'({core_x1, core_x2}), 32'h4000_0000);
    check("basic_busy", 32'(busy), 32'd1);
    handshake_once();
    check("basic_idle_busy", 32'(busy), 32'd0);
    check("basic_idle_ready", 32'(in_ready), 32'd1);

    // Backpressure with toggling core output and in_valid held high
    exp_q.push_back({31'h1800_0000, 16'd2});
    send(31'h3000_0000);
    wait_out_valid(40);
    @(posedge clk); #1;
    core_toggle = 1'b1;
    in_valid    = 1'b1;
    in_data     = 31'h7FFF_FFFF;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      check("bp_out_valid", 32'(out_valid), 32'd1);
      check("bp_out_data",  32'(out_data),  32'h1800_0000);
      check("bp_in_ready",  32'(in_ready),  32'd0);
    end
    @(posedge clk); #1;
    in_valid    = 1'b0;
    in_data     = '0;
    core_toggle = 1'b0;
    handshake_once();

    // in_valid pulse during RUN is ignored
    exp_q.push_back({31'h0800_0000, 16'd3});
    send(31'h1000_0000);
    repeat (6) @(posedge clk);
    #1;
    in_valid = 1'b1;
    in_data  = 31'h7FFF_FFFF;
    @(negedge clk);
    check("ign_in_ready", 32'(in_ready), 32'd0);
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_data  = '0;
    @(negedge clk);
    check("ign_core_x", 32'({core_x1, core_x2}), 32'h1000_0000);
    wait_out_valid(40);
    check("ign_core_x_out", 32'({core_x1, core_x2}), 32'h1000_0000);
    handshake_once();

    // Asynchronous reset in the middle of RUN
    exp_q.push_back({31'h2000_0000, 16'd4});
    send(31'h4000_0000);
    repeat (7) @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    check("mr_core_rst",   32'(core_rst),   32'd1);
    check("mr_out_valid",  32'(out_valid),  32'd0);
    check("mr_busy",       32'(busy),       32'd0);
    check("mr_in_ready",   32'(in_ready),   32'd0);
    check("mr_sample_cnt", 32'(sample_cnt), 32'd0);
    check("mr_core_x",     32'({core_x1, core_x2}), 32'd0);
    exp_q.delete();
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("mr_in_ready_release", 32'(in_ready), 32'd1);
    check("mr_cnt_release", 32'(sample_cnt), 32'd0);

    // Counter wrap and back-to-back accepts
    @(posedge clk); #1;
    force dut.sample_cnt_reg = 16'hFFFF;
    @(posedge clk); #1;
    release dut.sample_cnt_reg;
    @(negedge clk);
    check("wrap_preload", 32'(sample_cnt), 32'h0000_FFFF);
    exp_q.push_back({31'h2000_0000, 16'h0000});
    exp_q.push_back({31'h2000_0000, 16'h0001});
    @(posedge clk); #1;
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_data   = 31'h4000_0000;
    n_acc = 0;
    guard = 0;
    acc[0] = 0;
    acc[1] = 0;
    while (n_acc < 2 && guard < 100) begin
      @(negedge clk);
      guard++;
      if (in_valid && in_ready) begin
        acc[n_acc] = cyc;
        n_acc++;
      end
      if (n_acc == 1 && (cyc - acc[0]) == 8)
        check("ready_outside_out", 32'(sample_cnt), 32'h0000_FFFF);
    end
    check("b2b_accepts", 32'(n_acc), 32'd2);
    check("b2b_spacing", 32'(acc[1] - acc[0]), 32'd16);
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_data  = '0;
    wait_out_valid(40);
    @(negedge clk);
    @(negedge clk);
    @(posedge clk); #1;
    out_ready = 1'b0;

    repeat (3) @(negedge clk);
    check("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
